// File: rtl/mem_access_sched.sv
// Data-memory access scheduler: arbitrates loads vs. committing stores,
// issues one access per cycle to the memory, and returns tagged results.
// Ports: clk/rst/flush; ld_* and st_* request/grant handshakes;
// dm_* registered memory interface plus dm_result read data;
// res_* one-cycle completion strobe with tag, data and invalid flag.
module mem_access_sched #(
  parameter int ROBEN_W      = 5,
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ld_req,
  input  logic [ROBEN_W-1:0] ld_roben,
  input  logic [31:0]        ld_base,
  input  logic [31:0]        ld_imm,
  output logic               ld_grant,
  input  logic               st_req,
  input  logic [ROBEN_W-1:0] st_roben,
  input  logic [31:0]        st_base,
  input  logic [31:0]        st_imm,
  input  logic [31:0]        st_data,
  output logic               st_grant,
  output logic [31:0]        dm_address,
  output logic [31:0]        dm_data,
  output logic               dm_read_en,
  output logic               dm_write_en,
  output logic [ROBEN_W-1:0] dm_roben,
  input  logic [31:0]        dm_result,
  output logic               res_valid,
  output logic [ROBEN_W-1:0] res_roben,
  output logic [31:0]        res_data,
  output logic               res_invalid
);

  localparam int          CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] TOP = 32'(MEM_SIZE - 1);

  typedef enum logic {PRIO_ST, PRIO_LD} prio_e;

  prio_e         state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          iss_valid_q, iss_ld_q, iss_inv_q;
  logic [31:0]   ld_ea, st_ea, sel_ea;
  logic          sel_inv, any_grant, keep;

  assign ld_ea     = ld_base + ld_imm;
  assign st_ea     = st_base + st_imm;
  assign any_grant = ld_grant | st_grant;
  assign sel_ea    = st_grant ? st_ea : ld_ea;
  assign sel_inv   = sel_ea > TOP;
  // a flush while a load sits in issue kills its completion
  assign keep      = iss_valid_q & ~(iss_ld_q & flush);

  // a flushed load frees the slot for a waiting store
  always_comb begin
    ld_grant = 1'b0;
    st_grant = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PRIO_ST: begin
          st_grant = st_req;
          ld_grant = ld_req & ~flush & ~st_req;
        end
        PRIO_LD: begin
          ld_grant = ld_req & ~flush;
          st_grant = st_req & ~ld_grant;
        end
        default: ;
      endcase
    end
  end

  // count stores that overtake a waiting, unflushed load
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (ld_grant || !ld_req)
      starve_d = '0;
    else if (st_grant && !flush)
      starve_d = starve_q + CW'(1);
    if (ld_grant)
      state_d = PRIO_ST;
    if (starve_d == CW'(STARVE_LIMIT)) begin
      state_d  = PRIO_LD;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRIO_ST;
      starve_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_ld_q    <= 1'b0;
      iss_inv_q   <= 1'b0;
      dm_address  <= '0;
      dm_data     <= '0;
      dm_read_en  <= 1'b0;
      dm_write_en <= 1'b0;
      dm_roben    <= '0;
      res_valid   <= 1'b0;
      res_roben   <= '0;
      res_data    <= '0;
      res_invalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      iss_valid_q <= any_grant;
      iss_ld_q    <= ld_grant;
      iss_inv_q   <= sel_inv;
      dm_read_en  <= ld_grant & ~sel_inv;
      dm_write_en <= st_grant & ~sel_inv;
      if (any_grant) begin
        dm_roben <= st_grant ? st_roben : ld_roben;
        // out-of-range accesses never reach the memory address bus
        if (!sel_inv) begin
          dm_address <= sel_ea;
          dm_data    <= st_grant ? st_data : '0;
        end
      end
      res_valid   <= keep;
      res_roben   <= keep ? dm_roben : '0;
      res_invalid <= keep & iss_inv_q;
      res_data    <= (keep & iss_ld_q & ~iss_inv_q) ? dm_result : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: directed scenarios plus a randomized
// run checked against a queue-based reference of the access rules.
module tb_mem_access_sched;

  localparam int RW = 5;
  localparam int MS = 1024;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          ld_req = 1'b0;
  logic [RW-1:0] ld_roben = '0;
  logic [31:0]   ld_base = '0;
  logic [31:0]   ld_imm = '0;
  logic          ld_grant;
  logic          st_req = 1'b0;
  logic [RW-1:0] st_roben = '0;
  logic [31:0]   st_base = '0;
  logic [31:0]   st_imm = '0;
  logic [31:0]   st_data = '0;
  logic          st_grant;
  logic [31:0]   dm_address, dm_data, dm_result;
  logic          dm_read_en, dm_write_en;
  logic [RW-1:0] dm_roben;
  logic          res_valid, res_invalid;
  logic [RW-1:0] res_roben;
  logic [31:0]   res_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_sched #(.ROBEN_W(RW), .MEM_SIZE(MS), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req(ld_req), .ld_roben(ld_roben), .ld_base(ld_base),
    .ld_imm(ld_imm), .ld_grant(ld_grant),
    .st_req(st_req), .st_roben(st_roben), .st_base(st_base),
    .st_imm(st_imm), .st_data(st_data), .st_grant(st_grant),
    .dm_address(dm_address), .dm_data(dm_data),
    .dm_read_en(dm_read_en), .dm_write_en(dm_write_en),
    .dm_roben(dm_roben), .dm_result(dm_result),
    .res_valid(res_valid), .res_roben(res_roben),
    .res_data(res_data), .res_invalid(res_invalid)
  );

  always #5 clk = ~clk;

  // harness memory: acts on the negedge of the issue cycle
  logic [31:0] mem [MS];
  logic        fill = 1'b0;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [31:0] poke_val = '0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    if (fill)
      for (int i = 0; i < MS; i++) mem[i] <= init_word(i);
    if (poke_en) mem[poke_addr] <= poke_val;
    if (dm_write_en) mem[dm_address[9:0]] <= dm_data;
    if (dm_read_en) dm_result <= mem[dm_address[9:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 1'b0;
    st_req = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ld(logic [RW-1:0] t, logic [31:0] b, logic [31:0] i);
    ld_req = 1'b1; ld_roben = t; ld_base = b; ld_imm = i;
  endtask

  task automatic set_st(logic [RW-1:0] t, logic [31:0] b, logic [31:0] i,
                        logic [31:0] d);
    st_req = 1'b1; st_roben = t; st_base = b; st_imm = i; st_data = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dm_read_en, dm_write_en, res_valid, res_invalid} !== 4'b0 ||
        dm_address !== '0 || dm_data !== '0 || dm_roben !== '0 ||
        res_roben !== '0 || res_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rd=%b wr=%b rv=%b addr=%h want all 0",
               dm_read_en, dm_write_en, res_valid, dm_address);
    end
    set_st(1, 0, 0, 1);
    set_ld(2, 0, 0);
    #1;
    n_cmp++;
    if ({ld_grant, st_grant} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_grants got ld=%b st=%b want 0 0", ld_grant, st_grant);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_res got %b want 0", res_valid);
    end
  endtask

  task automatic test_load();
    poke_addr = 10'd104; poke_val = 32'h0000_DEAD; poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
    set_ld(3, 100, 4);
    #1;
    n_cmp++;
    if ({ld_grant, st_grant} !== 2'b10) begin
      n_err++;
      $display("FAIL load_grant got ld=%b st=%b want 1 0", ld_grant, st_grant);
    end
    tick();
    ld_req = 1'b0;
    n_cmp++;
    if (dm_read_en !== 1'b1 || dm_write_en !== 1'b0 ||
        dm_address !== 32'd104 || dm_roben !== 5'd3) begin
      n_err++;
      $display("FAIL load_issue got rd=%b wr=%b addr=%0d tag=%0d want 1 0 104 3",
               dm_read_en, dm_write_en, dm_address, dm_roben);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_roben !== 5'd3 ||
        res_data !== 32'hDEAD || res_invalid !== 1'b0) begin
      n_err++;
      $display("FAIL load_result got v=%b tag=%0d data=%h inv=%b want 1 3 dead 0",
               res_valid, res_roben, res_data, res_invalid);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_one_shot got %b want 0", res_valid);
    end
  endtask

  task automatic test_store();
    set_st(5, 10, 32'hFFFF_FFFE, 7);
    #1;
    n_cmp++;
    if ({ld_grant, st_grant} !== 2'b01) begin
      n_err++;
      $display("FAIL store_grant got ld=%b st=%b want 0 1", ld_grant, st_grant);
    end
    tick();
    st_req = 1'b0;
    n_cmp++;
    if (dm_write_en !== 1'b1 || dm_read_en !== 1'b0 ||
        dm_address !== 32'd8 || dm_data !== 32'd7 || dm_roben !== 5'd5) begin
      n_err++;
      $display("FAIL store_issue got wr=%b addr=%0d data=%0d want 1 8 7",
               dm_write_en, dm_address, dm_data);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_roben !== 5'd5 ||
        res_data !== 32'd0 || res_invalid !== 1'b0) begin
      n_err++;
      $display("FAIL store_result got v=%b tag=%0d data=%h want 1 5 0",
               res_valid, res_roben, res_data);
    end
    set_ld(6, 8, 0);
    tick();
    ld_req = 1'b0;
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_roben !== 5'd6 || res_data !== 32'd7) begin
      n_err++;
      $display("FAIL store_readback got v=%b tag=%0d data=%h want 1 6 7",
               res_valid, res_roben, res_data);
    end
  endtask

  task automatic test_invalid();
    set_ld(9, 1020, 8);
    tick();
    ld_req = 1'b0;
    n_cmp++;
    if (dm_read_en !== 1'b0 || dm_write_en !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_issue got rd=%b wr=%b want 0 0",
               dm_read_en, dm_write_en);
    end
    set_ld(10, 1023, 0);
    tick();
    ld_req = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_invalid !== 1'b1 ||
        res_data !== 32'd0 || res_roben !== 5'd9) begin
      n_err++;
      $display("FAIL invalid_result got v=%b inv=%b data=%h tag=%0d want 1 1 0 9",
               res_valid, res_invalid, res_data, res_roben);
    end
    n_cmp++;
    if (dm_read_en !== 1'b1 || dm_address !== 32'd1023) begin
      n_err++;
      $display("FAIL top_word_issue got rd=%b addr=%0d want 1 1023",
               dm_read_en, dm_address);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_invalid !== 1'b0 || res_roben !== 5'd10) begin
      n_err++;
      $display("FAIL top_word_result got v=%b inv=%b tag=%0d want 1 0 10",
               res_valid, res_invalid, res_roben);
    end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    set_ld(1, 200, 0);
    set_st(2, 300, 0, 32'h55);
    for (int i = 0; i < 15; i++) begin
      #1;
      n_cmp++;
      if ({ld_grant, st_grant} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL starve_pattern cycle %0d got ld=%b st=%b want %s",
                 i, ld_grant, st_grant, (i % 5 == 4) ? "load" : "store");
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_ld(1, 50, 0);
    #1;
    n_cmp++;
    if (ld_grant !== 1'b1) begin
      n_err++;
      $display("FAIL flush_first_grant got %b want 1", ld_grant);
    end
    tick();
    set_ld(2, 51, 0);
    set_st(4, 60, 0, 32'h1234);
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({ld_grant, st_grant} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_grants got ld=%b st=%b want 0 1", ld_grant, st_grant);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop got res_valid=%b want 0", res_valid);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || res_roben !== 5'd4 || res_data !== 32'd0) begin
      n_err++;
      $display("FAIL flush_store_done got v=%b tag=%0d data=%h want 1 4 0",
               res_valid, res_roben, res_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ld(7, 104, 0);
    tick();
    ld_req = 1'b0;
    n_cmp++;
    if (dm_read_en !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got rd=%b want 1", dm_read_en);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dm_read_en, dm_write_en, res_valid} !== 3'b0 ||
        dm_address !== '0 || dm_roben !== '0) begin
      n_err++;
      $display("FAIL midrst_clear got rd=%b addr=%0d tag=%0d rv=%b want 0",
               dm_read_en, dm_address, dm_roben, res_valid);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_no_result cycle %0d got %b want 0", i, res_valid);
      end
    end
  endtask

  typedef struct {
    int          due;
    logic [4:0]  tag;
    logic [31:0] data;
    bit          inv;
    bit          ld;
  } exp_t;

  task automatic test_random();
    logic [31:0] ref_mem [MS];
    exp_t        q[$];
    bit          lp, sp, prio_ld, gl, gs;
    int          waits;
    logic [31:0] ea;
    do_reset();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    for (int i = 0; i < MS; i++) ref_mem[i] = init_word(i);
    lp = 0; sp = 0; prio_ld = 0; waits = 0;
    for (int t = 0; t < 600; t++) begin
      // completions due this cycle
      if (q.size() > 0 && q[0].due == t) begin
        n_cmp++;
        if (res_valid !== 1'b1 || res_roben !== q[0].tag ||
            res_data !== q[0].data || res_invalid !== q[0].inv) begin
          n_err++;
          $display("FAIL rand_result t=%0d got v=%b tag=%0d d=%h inv=%b want 1 %0d %h %b",
                   t, res_valid, res_roben, res_data, res_invalid,
                   q[0].tag, q[0].data, q[0].inv);
        end
        void'(q.pop_front());
      end else begin
        n_cmp++;
        if (res_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rand_spurious t=%0d got res_valid=%b want 0", t, res_valid);
        end
      end
      // new requests while the traffic window is open
      if (t < 590) begin
        if (!lp && $urandom_range(0, 2) == 0) begin
          lp = 1;
          ld_roben = RW'($urandom);
          ld_base  = $urandom_range(0, 1100);
          ld_imm   = 32'($urandom_range(0, 40)) - 32'd20;
        end
        if (!sp && $urandom_range(0, 2) == 0) begin
          sp = 1;
          st_roben = RW'($urandom);
          st_base  = $urandom_range(0, 1100);
          st_imm   = 32'($urandom_range(0, 40)) - 32'd20;
          st_data  = $urandom;
        end
        flush = ($urandom_range(0, 7) == 0);
      end else begin
        flush = 1'b0;
      end
      ld_req = lp;
      st_req = sp;
      #1;
      // arbitration from the priority rules
      if (prio_ld) begin
        gl = lp && !flush;
        gs = sp && !gl;
      end else begin
        gs = sp;
        gl = lp && !flush && !sp;
      end
      n_cmp++;
      if (ld_grant !== gl || st_grant !== gs) begin
        n_err++;
        $display("FAIL rand_grant t=%0d got ld=%b st=%b want %b %b",
                 t, ld_grant, st_grant, gl, gs);
      end
      if (flush)
        for (int k = q.size() - 1; k >= 0; k--)
          if (q[k].ld && q[k].due == t + 1) q.delete(k);
      if (gs) begin
        ea = st_base + st_imm;
        q.push_back('{t + 2, st_roben, 32'd0, ea > 32'(MS - 1), 1'b0});
        if (ea <= 32'(MS - 1)) ref_mem[ea[9:0]] = st_data;
      end
      if (gl) begin
        ea = ld_base + ld_imm;
        q.push_back('{t + 2, ld_roben,
                      (ea > 32'(MS - 1)) ? 32'd0 : ref_mem[ea[9:0]],
                      ea > 32'(MS - 1), 1'b1});
      end
      // stores that overtake a waiting load, flush cycles excluded
      if (gl || !lp) waits = 0;
      else if (gs && !flush) waits++;
      if (gl) prio_ld = 0;
      if (waits == SL) begin
        prio_ld = 1;
        waits = 0;
      end
      if (gl) lp = 0;
      if (gs) sp = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_load();
    test_store();
    test_invalid();
    test_starvation();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_sched.md
# mem_access_sched

Scheduler that sequences the single-ported data memory between two requesters: the load buffer (speculative loads) and the commit path (retiring stores). Each cycle it grants at most one request, computes the effective address, blocks out-of-range accesses, drives the memory's read/write/ROBEN inputs, and returns a tagged result for the common data bus. It sits between the load/store buffer and the data memory in the memory unit.

## Interface

- ROBEN_W, 5, ROB entry tag width (`ROB_SIZE_bits`+1)
- MEM_SIZE, 1024, number of 32-bit words; valid indices 0..MEM_SIZE-1
- STARVE_LIMIT, 4, consecutive store grants with a waiting load before the load is forced through

Ports:

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  mispredict flush; kills speculative loads
- ld_req  in  1  load request, held until ld_grant
- ld_roben  in  ROBEN_W  load ROB tag
- ld_base  in  32  load base register value
- ld_imm  in  32  load immediate
- ld_grant  out  1  combinational; load accepted this cycle
- st_req  in  1  store request from commit, held until st_grant
- st_roben  in  ROBEN_W  store ROB tag
- st_base  in  32  store base value
- st_imm  in  32  store immediate
- st_data  in  32  store data
- st_grant  out  1  combinational; store accepted this cycle
- dm_address  out  32  registered memory address
- dm_data  out  32  registered write data
- dm_read_en  out  1  registered read enable
- dm_write_en  out  1  registered write enable
- dm_roben  out  ROBEN_W  registered tag to memory
- dm_result  in  32  memory read data, valid at the posedge after issue
- res_valid  out  1  result/completion strobe, one cycle
- res_roben  out  ROBEN_W  tag of completing access
- res_data  out  32  load data (0 for stores and invalid accesses)
- res_invalid  out  1  effective address > MEM_SIZE-1

## Operation

- Effective address = base + imm, 32-bit wrap. Invalid if unsigned result > MEM_SIZE-1.
- Arbitration FSM, two states:
  - PRIO_ST (reset state): st_req wins; else ld_req wins.
  - PRIO_LD: ld_req wins; after that load grant return to PRIO_ST.
- starve_cnt: +1 on a store grant while ld_req=1; cleared on any load grant, or when ld_req=0. When starve_cnt reaches STARVE_LIMIT, go to PRIO_LD and clear starve_cnt.
- flush=1 forces ld_grant=0 that cycle; st_grant unaffected.
- Issue stage (posedge after grant): valid access drives dm_address/dm_data/dm_roben and dm_read_en (load) or dm_write_en (store). Invalid access issues with both enables 0 but is still tracked.
- Idle cycle: both enables 0; other issue registers hold.
- Result stage (next posedge): res_valid=1, res_roben, res_invalid. Valid load: res_data=dm_result. Store or invalid: res_data=0.
- flush=1 while a load is in the issue stage: that load's result is dropped (res_valid=0 next cycle); its memory read is harmless. Stores are never dropped.

## Timing

- Grant: combinational, same cycle as request.
- Grant at posedge N edge window -> issue registers at posedge N+1 -> memory acts on negedge within N+1 -> res_valid at posedge N+2. Latency 2 cycles; throughput 1 access/cycle, back-to-back allowed.
- Reset: all outputs 0, FSM=PRIO_ST, starve_cnt=0, pipeline empty. Reset mid-operation discards in-flight accesses; no res_valid after release until a new grant.
- Both requests and flush in one cycle: store granted, load not, starve_cnt unchanged.

## Test plan

- Single load, base=100, imm=4, ld_roben=3, mem[104]=0xDEAD -> dm_read_en=1, dm_address=104 at N+1; res_valid, res_roben=3, res_data=0xDEAD at N+2.
- Store base=10, imm=-2, data=7, tag 5 -> dm_write_en=1, dm_address=8; res_valid with tag 5, res_data=0; subsequent load of 8 returns 7.
- Load base=1020, imm=8 (MEM_SIZE=1024) -> both enables 0, res_valid=1, res_invalid=1, res_data=0.
- ld_req and st_req held continuously -> 4 store grants, then 1 load grant, repeating.
- Load granted at N, flush at N+1 -> no res_valid at N+2; concurrent store still completes.
- rst asserted with a load in issue stage -> all outputs 0 immediately; no res_valid after release.
